// File: rtl/inst_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared constants, the FSM state encoding, the buffered-entry layout and
// small PC helpers used by the instruction fetch unit and its buffer.
// ---------------------------------------------------------------------------
package inst_fetch_unit_pkg;

    // PC loaded on reset unless the instantiating block overrides it.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // Canonical bubble (addi x0,x0,0), used by a later pipeline stage.
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    // Fetch FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;  // nothing outstanding
    localparam logic [1:0] ST_WAIT = 2'd1;  // one request outstanding, keep data
    localparam logic [1:0] ST_DROP = 2'd2;  // one request outstanding, discard data

    // One buffered instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Sequential next PC; wraps naturally from 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the instruction-memory port and the decoder port of the fetch unit.
//   imem_req/imem_addr      fetch -> memory  read request, word address
//   imem_ready              memory -> fetch  request accepted this cycle
//   imem_rvalid/imem_rdata  memory -> fetch  returned instruction word
//   inst_valid/inst/inst_pc fetch -> decoder buffered instruction and its PC
//   inst_ready              decoder -> fetch head consumed this cycle
// master = fetch unit side, slave = memory/decoder side.
// ---------------------------------------------------------------------------
interface inst_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding {pc, inst} entries for the fetch unit.
//   clk, rst   clock, synchronous active-high reset
//   flush_i    empty the buffer; cancels a same-cycle push or pop
//   push_i     write wdata_i (ignored when full)
//   pop_i      drop the head entry (ignored when empty)
//   rdata_o    head entry, read straight from the storage registers
//   full_o, empty_o, count_o  occupancy
// DEPTH must be a power of two so the pointers wrap on their own.
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (count_q == CNT_W'(DEPTH));
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign do_push_s = push_i && !full_s && !flush_i;
    assign do_pop_s  = pop_i && !empty_s && !flush_i;

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign count_o = count_q;

    // Storage, pointers and occupancy; flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (flush_i) begin
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Fetch stage: holds the PC, issues one word-aligned instruction read at a
// time, buffers returned words with their PCs and hands them to the decoder.
//   clk, rst        clock, synchronous active-high reset
//   redirect_valid  load redirect_pc (low two bits ignored) and flush
//   redirect_pc     new fetch target
//   bus             memory request/response and decoder valid/ready
// Parameters: RESET_PC (PC after reset), FIFO_DEPTH (buffer entries).
// ---------------------------------------------------------------------------
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    inst_fetch_unit_if.master   bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    // Set by reset so the bus stays quiet during the first cycle after it.
    logic             rst_hold_q;

    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             imem_req_s;
    logic             accept_s;
    logic             rsp_s;
    logic             push_s;
    logic             pop_s;
    fetch_entry_t     wdata_s;
    fetch_entry_t     head_s;

    // Request only from IDLE and only while a slot is guaranteed for the
    // response, so occupancy plus outstanding never exceeds the depth.
    assign imem_req_s = (state_q == ST_IDLE) && (count_s < CNT_W'(FIFO_DEPTH)) && !rst_hold_q;
    assign accept_s   = imem_req_s && bus.imem_ready;
    assign rsp_s      = (state_q == ST_WAIT) && bus.imem_rvalid;
    assign push_s     = rsp_s && !full_s;
    assign pop_s      = !empty_s && bus.inst_ready;
    assign wdata_s    = '{pc: req_pc_q, inst: bus.imem_rdata};

    // FSM next state and PC; redirect overrides the sequential PC.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // An accepted request cannot be recalled; drop its data.
                    state_d  = redirect_valid ? ST_DROP : ST_WAIT;
                    req_pc_d = pc_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = ST_IDLE;
                end else if (redirect_valid) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (bus.imem_rvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (accept_s) begin
            pc_d = next_pc(pc_q);
        end else begin
            pc_d = pc_q;
        end
    end

    // FSM, PC and request-PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0000_0000;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            rst_hold_q <= 1'b0;
        end
    end

    // A redirect flushes the buffer, which also cancels the response push
    // that WAIT+rvalid would otherwise produce in that cycle.
    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push_s),
        .wdata_i (wdata_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    assign bus.imem_req   = imem_req_s;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = !empty_s;
    assign bus.inst       = head_s.inst;
    assign bus.inst_pc    = head_s.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          keep;
    } pend_t;

    typedef struct {
        int          rdy_delay;
        int          lat;
        bit          irdy;
        logic [31:0] exp_addr;
    } vec_t;

    pend_t        pend_q[$];
    fetch_entry_t exp_q[$];

    bit          c_rst, c_ready, c_irdy, c_redir;
    logic [31:0] c_redir_pc;
    int          c_lat;
    int          cyc = 0;
    bit          model_ok = 1'b0;
    logic [31:0] exp_pc;
    bit          acc_seen, pop_seen;
    logic [31:0] acc_addr, pop_pc;
    int          n_acc, n_pop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // One clock: drive inputs, check outputs, advance the model, cross the edge.
    task automatic cycle();
        bit    rv, acc, pop;
        pend_t p;
        rst            = c_rst;
        redirect_valid = c_redir;
        redirect_pc    = c_redir_pc;
        bus.imem_ready = c_ready;
        bus.inst_ready = c_irdy;
        rv = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? mem_word(pend_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        acc = bus.imem_req && c_ready;
        pop = bus.inst_valid && c_irdy;
        acc_seen = 1'b0;
        pop_seen = 1'b0;
        acc_addr = bus.imem_addr;
        if (model_ok) begin
            check1("inst_valid", bus.inst_valid, exp_q.size() != 0);
            if (bus.imem_req) check32("imem_addr", bus.imem_addr, exp_pc);
            check1("no_push_into_full", dut.rsp_s && dut.full_s, 1'b0);
            if (bus.inst_valid && exp_q.size() != 0) begin
                check32("inst_pc", bus.inst_pc, exp_q[0].pc);
                check32("inst", bus.inst, exp_q[0].inst);
            end
        end
        if (rv) p = pend_q.pop_front();
        if (c_rst) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].keep = 1'b0;
            if (acc) pend_q.push_back('{addr: bus.imem_addr, due: cyc + c_lat, keep: 1'b0});
            exp_pc   = RST_PC;
            model_ok = 1'b1;
        end else if (c_redir) begin
            exp_q.delete();
            foreach (pend_q[i]) pend_q[i].keep = 1'b0;
            if (acc) pend_q.push_back('{addr: bus.imem_addr, due: cyc + c_lat, keep: 1'b0});
            exp_pc = {c_redir_pc[31:2], 2'b00};
        end else begin
            if (pop && exp_q.size() != 0) begin
                pop_seen = 1'b1;
                pop_pc   = bus.inst_pc;
                n_pop++;
                void'(exp_q.pop_front());
            end
            if (rv && p.keep) exp_q.push_back('{pc: p.addr, inst: mem_word(p.addr)});
            if (acc) begin
                pend_q.push_back('{addr: bus.imem_addr, due: cyc + c_lat, keep: 1'b1});
                acc_seen = 1'b1;
                exp_pc   = exp_pc + 32'd4;
                n_acc++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_acc(input string name, input logic [31:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            got = acc_seen;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: no request accepted, want addr %h", name, exp);
        end else begin
            check32(name, acc_addr, exp);
        end
    endtask

    task automatic wait_pop(input string name, input logic [31:0] exp);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            got = pop_seen;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s: no instruction delivered, want pc %h", name, exp);
        end else begin
            check32(name, pop_pc, exp);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{rdy_delay: 0, lat: 1, irdy: 1'b1, exp_addr: 32'h0000_0100};
        vecs[1] = '{rdy_delay: 0, lat: 1, irdy: 1'b1, exp_addr: 32'h0000_0104};
        vecs[2] = '{rdy_delay: 0, lat: 1, irdy: 1'b1, exp_addr: 32'h0000_0108};
        vecs[3] = '{rdy_delay: 2, lat: 2, irdy: 1'b1, exp_addr: 32'h0000_010C};
        vecs[4] = '{rdy_delay: 0, lat: 3, irdy: 1'b0, exp_addr: 32'h0000_0110};
        vecs[5] = '{rdy_delay: 1, lat: 1, irdy: 1'b1, exp_addr: 32'h0000_0114};
        vecs[6] = '{rdy_delay: 0, lat: 2, irdy: 1'b1, exp_addr: 32'h0000_0118};
        vecs[7] = '{rdy_delay: 3, lat: 1, irdy: 1'b0, exp_addr: 32'h0000_011C};

        c_rst = 1'b1; c_ready = 1'b1; c_irdy = 1'b1; c_redir = 1'b0;
        c_redir_pc = 32'h0; c_lat = 1;
        run(2);
        // Quiet bus in the first cycle after reset.
        check1("rst_imem_req", bus.imem_req, 1'b0);
        check1("rst_inst_valid", bus.inst_valid, 1'b0);
        check32("rst_inst", bus.inst, 32'h0);
        check32("rst_inst_pc", bus.inst_pc, 32'h0);
        c_rst = 1'b0;

        // Table: sequential fetch under varying memory/decoder behaviour.
        n_pop = 0;
        foreach (vecs[k]) begin
            c_irdy = vecs[k].irdy;
            c_lat  = vecs[k].lat;
            c_ready = 1'b0;
            run(vecs[k].rdy_delay);
            c_ready = 1'b1;
            wait_acc($sformatf("vec%0d_addr", k), vecs[k].exp_addr);
        end
        c_ready = 1'b0; c_irdy = 1'b1;
        run(8);
        check32("vec_delivered", n_pop, 32'd8);
        check32("vec_drained", exp_q.size(), 32'd0);

        // Decoder stall: buffer fills with two entries and the bus goes idle.
        c_rst = 1'b1; run(1); c_rst = 1'b0;
        c_irdy = 1'b0; c_ready = 1'b1; c_lat = 1; n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.inst_valid) begin
                check32("stall_inst_pc", bus.inst_pc, 32'h0000_0100);
                check32("stall_inst", bus.inst, mem_word(32'h0000_0100));
            end
        end
        check32("stall_fetched", n_acc, 32'd2);
        check1("stall_req_low", bus.imem_req, 1'b0);
        c_irdy = 1'b1;
        wait_pop("release_0", 32'h0000_0100);
        wait_pop("release_1", 32'h0000_0104);
        wait_pop("release_2", 32'h0000_0108);

        // Redirect while WAIT; the response arrives three cycles later.
        c_lat = 4;
        wait_acc("pre_redirect_acc", exp_pc);
        c_redir = 1'b1; c_redir_pc = 32'h0000_2003; c_lat = 1;
        cycle();
        c_redir = 1'b0;
        check1("redir_wait_flush", bus.inst_valid, 1'b0);
        check1("redir_wait_drop_req", bus.imem_req, 1'b0);
        wait_acc("redir_wait_next_addr", 32'h0000_2000);
        wait_pop("redir_wait_first_pc", 32'h0000_2000);

        // Redirect in the same cycle the request at 0x40 is accepted.
        c_ready = 1'b0;
        for (int i = 0; i < 40 && !(bus.imem_req && pend_q.size() == 0); i++) cycle();
        c_redir = 1'b1; c_redir_pc = 32'h0000_0040;
        cycle();
        check1("pc40_req", bus.imem_req, 1'b1);
        check32("pc40_addr", bus.imem_addr, 32'h0000_0040);
        c_ready = 1'b1; c_redir_pc = 32'h0000_0300; c_lat = 2;
        cycle();
        c_redir = 1'b0;
        check1("same_cycle_drop_req", bus.imem_req, 1'b0);
        wait_acc("same_cycle_next_addr", 32'h0000_0300);
        wait_pop("same_cycle_first_pc", 32'h0000_0300);

        // PC wrap at the top of the address space.
        c_irdy = 1'b0; c_lat = 1;
        c_redir = 1'b1; c_redir_pc = 32'hFFFF_FFFE;
        cycle();
        c_redir = 1'b0;
        wait_acc("wrap_addr_top", 32'hFFFF_FFFC);
        wait_acc("wrap_addr_zero", 32'h0000_0000);
        c_irdy = 1'b1;
        wait_pop("wrap_pop_top", 32'hFFFF_FFFC);
        wait_pop("wrap_pop_zero", 32'h0000_0000);

        // Reset during WAIT; stray response in the cycle after reset.
        c_lat = 2;
        wait_acc("pre_reset_acc", exp_pc);
        c_rst = 1'b1;
        cycle();
        c_rst = 1'b0;
        check1("wait_rst_req", bus.imem_req, 1'b0);
        check1("wait_rst_valid", bus.inst_valid, 1'b0);
        c_lat = 1;
        cycle();
        check1("stray_ignored_valid", bus.inst_valid, 1'b0);
        check1("stray_req", bus.imem_req, 1'b1);
        check32("stray_addr", bus.imem_addr, RST_PC);
        wait_acc("post_rst_addr", RST_PC);
        wait_pop("post_rst_pc", RST_PC);

        // Random traffic with occasional redirects, checked by the scoreboard.
        for (int i = 0; i < 800; i++) begin
            c_ready    = ($urandom_range(0, 3) != 0);
            c_irdy     = ($urandom_range(0, 2) != 0);
            c_lat      = $urandom_range(1, 3);
            c_redir    = ($urandom_range(0, 15) == 0);
            c_redir_pc = $urandom;
            cycle();
        end
        c_redir = 1'b0; c_ready = 1'b0; c_irdy = 1'b1;
        run(10);
        check32("final_drained", exp_q.size(), 32'd0);
        check1("final_valid", bus.inst_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
